// File: rtl/pcs_tx_sched_if.sv
// Scheduler-side bundle for the 40G PCS transmit block-slot scheduler.
// The master modport belongs to pcs_tx_sched. The slave modport belongs to the
// management/MAC/gearbox side, which drives en_i and observes the decisions.
// am_cnt_o exists only when PCS_TX_SCHED_STATS_EN is defined.
interface pcs_tx_sched_if #(
    parameter int SEQ_W = 6
);
    logic             en_i;
    logic [SEQ_W-1:0] seq_o;
    logic             slot_v_o;
    logic             marker_v_o;
    logic             scram_v_o;
    logic             ready_o;
`ifdef PCS_TX_SCHED_STATS_EN
    logic [15:0]      am_cnt_o;
`endif

    modport master (
        input  en_i,
        output seq_o,
        output slot_v_o,
        output marker_v_o,
        output scram_v_o,
`ifdef PCS_TX_SCHED_STATS_EN
        output am_cnt_o,
`endif
        output ready_o
    );

    modport slave (
        output en_i,
        input  seq_o,
        input  slot_v_o,
        input  marker_v_o,
        input  scram_v_o,
`ifdef PCS_TX_SCHED_STATS_EN
        input  am_cnt_o,
`endif
        input  ready_o
    );
endinterface

// File: rtl/pcs_tx_sched.sv
// Block-slot scheduler for the 40G PCS transmit path.
// Each cycle is exactly one of three things: a gearbox pause, an alignment-marker
// slot, or a MAC data slot. All outputs decode registered state only, so there is
// no combinational path from en_i to any output.
// Optional feature: define PCS_TX_SCHED_STATS_EN to add a saturating 16-bit
// count of markers sent (am_cnt_o). Only nreset clears it.
//
// state | meaning
// IDLE  | transmit disabled; seq/marker counters held at start values, no slots
// RUN   | gearbox sequence advancing; slots carry markers or MAC data
module pcs_tx_sched #(
    parameter int DATA_W    = 64,
    parameter int HEAD_W    = 2,
    parameter int SEQ_MAX   = DATA_W / HEAD_W,
    parameter int SEQ_W     = $clog2(SEQ_MAX + 1),
    parameter int AM_PERIOD = 16383,
    parameter int AM_W      = $clog2(AM_PERIOD + 1)
) (
    input  logic clk,
    input  logic nreset,
    pcs_tx_sched_if.master bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(SEQ_MAX);
    localparam logic [AM_W-1:0]  AM_LAST  = AM_W'(AM_PERIOD - 1);

    state_t           state_q, state_d;
    logic [SEQ_W-1:0] seq_q;
    logic [AM_W-1:0]  am_cnt_q;
    logic             am_due_q;
    logic             slot;
    logic             slot_v;
    logic             marker_v;
    logic             data_v;

    assign slot = (seq_q != SEQ_LAST);

    // State register: the registered copy of the transmit enable.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state follows en_i; slot decode comes from registered state only.
    always_comb begin
        state_d  = bus.en_i ? RUN : IDLE;
        slot_v   = 1'b0;
        marker_v = 1'b0;
        data_v   = 1'b0;
        if (state_q == RUN && slot) begin
            slot_v   = 1'b1;
            marker_v = am_due_q;
            data_v   = ~am_due_q;
        end
    end

    // Sequence and marker-period counters. Dropping en_i returns them to start
    // values on the same edge, so the first IDLE cycle already shows seq 0.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            seq_q    <= '0;
            am_cnt_q <= '0;
            am_due_q <= 1'b1;
        end else if (state_d == IDLE) begin
            seq_q    <= '0;
            am_cnt_q <= '0;
            am_due_q <= 1'b1;
        end else if (state_q == RUN) begin
            seq_q <= (seq_q == SEQ_LAST) ? '0 : seq_q + 1'b1;
            if (marker_v) begin
                am_due_q <= 1'b0;
                am_cnt_q <= '0;
            end else if (data_v) begin
                am_cnt_q <= am_cnt_q + 1'b1;
                if (am_cnt_q == AM_LAST) am_due_q <= 1'b1;
            end
        end
    end

    assign bus.seq_o      = seq_q;
    assign bus.slot_v_o   = slot_v;
    assign bus.marker_v_o = marker_v;
    assign bus.ready_o    = data_v;
    assign bus.scram_v_o  = data_v;

`ifdef PCS_TX_SCHED_STATS_EN
    logic [15:0] stat_q;

    // Saturating marker count; en_i deliberately has no effect on it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                             stat_q <= '0;
        else if (marker_v && stat_q != 16'hFFFF) stat_q <= stat_q + 1'b1;
    end

    assign bus.am_cnt_o = stat_q;
`else
    // Marker statistics are not built in this configuration.
`endif
endmodule

// File: tb/tb_pcs_tx_sched.sv
// Bench for pcs_tx_sched: instance A uses AM_PERIOD=8, instance B uses
// AM_PERIOD=31 so that the marker lines up with the gearbox pause.
// The reference works from counts: cycles since enable give the sequence,
// and slots since enable give marker positions (a marker every AM_PERIOD+1 slots).
module tb_pcs_tx_sched;
    localparam int SEQ_W = 6;
    localparam int SEQ_MAX = 32;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    pcs_tx_sched_if #(.SEQ_W(SEQ_W)) bus_a ();
    pcs_tx_sched_if #(.SEQ_W(SEQ_W)) bus_b ();

    pcs_tx_sched #(.AM_PERIOD(8))  dut_a (.clk(clk), .nreset(nreset), .bus(bus_a));
    pcs_tx_sched #(.AM_PERIOD(31)) dut_b (.clk(clk), .nreset(nreset), .bus(bus_b));

    int errors = 0;
    int checks = 0;

    int per [2] = '{8, 31};
    bit m_en [2];
    int m_cyc [2];
    int m_slot [2];
    int m_stat [2];
    int act_mk [2];
    int act_rdy [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_seq(input int i);
        return m_en[i] ? (m_cyc[i] % (SEQ_MAX + 1)) : 0;
    endfunction

    function automatic bit exp_slot(input int i);
        return m_en[i] && (exp_seq(i) != SEQ_MAX);
    endfunction

    function automatic bit exp_mk(input int i);
        return exp_slot(i) && ((m_slot[i] % (per[i] + 1)) == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_en[i] = 1'b0; m_cyc[i] = 0; m_slot[i] = 0; m_stat[i] = 0;
        end
    endtask

    // Advance the reference over one clock edge, given the enable seen at that edge.
    task automatic model_edge(input int i, input bit en);
        if (exp_mk(i) && m_stat[i] < 16'hFFFF) m_stat[i]++;
        if (!en || !m_en[i]) begin
            m_cyc[i] = 0;
            m_slot[i] = 0;
        end else begin
            if (exp_seq(i) != SEQ_MAX) m_slot[i]++;
            m_cyc[i]++;
        end
        m_en[i] = en;
    endtask

    task automatic check_inst(input int i);
        logic [SEQ_W-1:0] seq;
        logic sv, mk, sc, rd;
        string p;
        p = (i == 0) ? "a" : "b";
        seq = (i == 0) ? bus_a.seq_o      : bus_b.seq_o;
        sv  = (i == 0) ? bus_a.slot_v_o   : bus_b.slot_v_o;
        mk  = (i == 0) ? bus_a.marker_v_o : bus_b.marker_v_o;
        sc  = (i == 0) ? bus_a.scram_v_o  : bus_b.scram_v_o;
        rd  = (i == 0) ? bus_a.ready_o    : bus_b.ready_o;
        chk({p, "_seq"},    32'(seq), 32'(exp_seq(i)));
        chk({p, "_slot_v"}, 32'(sv),  32'(exp_slot(i)));
        chk({p, "_marker"}, 32'(mk),  32'(exp_mk(i)));
        chk({p, "_ready"},  32'(rd),  32'(exp_slot(i) && !exp_mk(i)));
        chk({p, "_scram"},  32'(sc),  32'(exp_slot(i) && !exp_mk(i)));
`ifdef PCS_TX_SCHED_STATS_EN
        chk({p, "_am_cnt"}, 32'((i == 0) ? bus_a.am_cnt_o : bus_b.am_cnt_o), 32'(m_stat[i]));
`endif
        act_mk[i]  += int'(mk);
        act_rdy[i] += int'(rd);
    endtask

    task automatic step(input bit ea, input bit eb);
        bus_a.en_i = ea;
        bus_b.en_i = eb;
        @(posedge clk);
        model_edge(0, ea);
        model_edge(1, eb);
        #1;
        check_inst(0);
        check_inst(1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_seq"}, 32'(bus_a.seq_o), 0);
        chk({tag, "_a_out"}, 32'({bus_a.slot_v_o, bus_a.marker_v_o, bus_a.ready_o, bus_a.scram_v_o}), 0);
        chk({tag, "_b_seq"}, 32'(bus_b.seq_o), 0);
        chk({tag, "_b_out"}, 32'({bus_b.slot_v_o, bus_b.marker_v_o, bus_b.ready_o, bus_b.scram_v_o}), 0);
    endtask

    initial begin
        int n;
        nreset = 1'b0;
        bus_a.en_i = 1'b0;
        bus_b.en_i = 1'b0;
        model_reset();
        #2;
        check_all_zero("reset");
        #10 nreset = 1'b1;
        step(0, 0);
        step(0, 0);

        // Start-up: first enabled cycle is a marker at seq 0, then 8 data slots.
        act_mk  = '{0, 0};
        act_rdy = '{0, 0};
        step(1, 1);
        chk("start_seq0", 32'(bus_a.seq_o), 0);
        chk("start_marker", 32'(bus_a.marker_v_o), 1);
        for (int c = 2; c <= 9; c++) step(1, 1);
        chk("start_data8", 32'(act_rdy[0]), 8);
        step(1, 1);
        chk("start_marker10", 32'(bus_a.marker_v_o), 1);

        // Run through the pause and three full gearbox rounds for instance B.
        for (int c = 11; c <= 99; c++) begin
            step(1, 1);
            if (c == 33) chk("pause_slot_v", 32'(bus_a.slot_v_o), 0);
            if (c == 34) chk("after_pause_seq", 32'(bus_a.seq_o), 0);
            if (c == 38) chk("next_round_seq4_mk", 32'({bus_a.seq_o, bus_a.marker_v_o}), 32'({6'd4, 1'b1}));
        end
        chk("coinc_markers", 32'(act_mk[1]), 3);
        chk("coinc_ready", 32'(act_rdy[1]), 93);

        // Disable at seq 17, then re-enable.
        n = 0;
        while (bus_a.seq_o != 6'd17 && n < 40) begin
            step(1, 1);
            n++;
        end
        chk("reach_seq17", 32'(n < 40), 1);
        step(0, 1);
        chk("dis_seq", 32'(bus_a.seq_o), 0);
        chk("dis_out", 32'({bus_a.slot_v_o, bus_a.marker_v_o, bus_a.ready_o}), 0);
        step(1, 1);
        chk("reen_marker", 32'(bus_a.marker_v_o), 1);

        // Random enable activity, mostly running.
        for (int c = 0; c < 1500; c++)
            step($urandom_range(99) >= 2, $urandom_range(99) >= 1);

        // Asynchronous reset mid-run, between clock edges.
        for (int c = 0; c < 20; c++) step(1, 1);
        #3 nreset = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_rst");
`ifdef PCS_TX_SCHED_STATS_EN
        chk("async_rst_am_cnt", 32'(bus_a.am_cnt_o), 0);
`endif
        #1 nreset = 1'b1;
        for (int c = 0; c < 60; c++) step(1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
